game_timer_gen: RTL and testbench
=================================

// Module: game_timer_gen
// PURPOSE
//  Produces the game_time count consumed by the level sequencer. Also produces stage-boundary
//  strobes and a stage index. Sits between the system clock and the level FSM.
//  Runs only while a level is active: frozen on menu and win screens, paused on the pause
//  button, and restarts at 0 with a respawn hold after a player death.
// PARAMETERS
//  TICK_DIV    2_500_000  clk cycles per game_time increment (10 Hz at 25 MHz)
//  STAGE_LEN   125        game_time ticks per stage
//  DEATH_HOLD  20         ticks game_time is held at 0 after a death before counting resumes
//  TIME_W      16         width of game_time
// PORTS
//  clk           in   1       system clock
//  reset         in   1       asynchronous, active-high
//  menuScreen    in   1       level FSM is in menu
//  winScreen     in   1       level FSM is in win/win-delay
//  playerDied    in   1       collision pulse/level; sampled every clk
//  pause_btn     in   1       synchronised, debounced pause button level
//  game_time     out  TIME_W  elapsed game ticks in the current run
//  tick          out  1       1-clk pulse, same cycle game_time takes its new value
//  stage_strobe  out  1       1-clk pulse when game_time becomes a nonzero multiple of STAGE_LEN
//  stage_idx     out  5       game_time / STAGE_LEN, saturating at 31
//  paused        out  1       high in PAUSED
// BEHAVIOUR
//  Reset: state=IDLE. game_time=0, tick=0, stage_strobe=0, stage_idx=0, paused=0.
//   Prescaler=0, sub-stage counter=0, pause edge register=0.
//  States: IDLE, RUN, PAUSED, HOLD, DONE. Transition priority per clk:
//   menuScreen > playerDied > winScreen > pause edge > tick logic.
//  IDLE: all counters held at 0. Exit to RUN when menuScreen=0 and winScreen=0.
//  RUN:
//   - Prescaler counts 0..TICK_DIV-1. On terminal count: prescaler->0, game_time+1, tick=1.
//   - Sub-stage counter +1. If it reaches STAGE_LEN: sub->0, stage_idx+1 (sat 31), stage_strobe=1.
//   - game_time saturates at 2^TIME_W-1. At saturation tick still pulses but no strobe fires.
//  playerDied=1 in RUN, PAUSED or HOLD:
//   - Next clk: state=HOLD. game_time, stage_idx, sub-stage and prescaler all cleared.
//   - tick and stage_strobe are 0 that cycle.
//   - Level held across cycles keeps re-entering HOLD, which restarts the hold count.
//  HOLD: prescaler runs; hold counter counts ticks, but game_time stays 0 and tick is not output.
//   After DEATH_HOLD ticks -> RUN, prescaler=0.
//  Pause edge (rising edge of pause_btn, registered detector):
//   - RUN -> PAUSED; PAUSED -> RUN. Ignored in IDLE, HOLD and DONE.
//   - Prescaler value is frozen and retained across the pause, not cleared.
//  winScreen=1 in RUN or PAUSED -> DONE. game_time frozen at its current value, paused=0.
//  menuScreen=1 in any state -> IDLE next clk, all counters cleared.
//  DONE: holds outputs. menuScreen -> IDLE.
//  Simultaneous cases:
//   - Tick terminal count and playerDied in the same clk: the death wins, and no tick or
//     strobe is emitted.
//   - Pause edge and tick terminal in the same clk: the pause wins, the tick is deferred,
//     and the prescaler stays at terminal.
//  Outputs are registered. No combinational path from inputs to outputs.
//  Latency: event inputs take effect on outputs 1 clk after sampling.
// TESTING (sim TICK_DIV=4, STAGE_LEN=5, DEATH_HOLD=3)
//  1) Reset, then menuScreen=0 -> game_time increments every 4 clk. stage_strobe at game_time=5,10.
//     stage_idx=2 at game_time=10.
//  2) playerDied 1 clk at game_time=7 -> next clk game_time=0, stage_idx=0.
//     Counting resumes after 12 clk (3 ticks). First tick gives game_time=1.
//  3) pause_btn rise at game_time=3 with prescaler=2 -> held 50 clk with paused=1.
//     Second rise -> next tick after 2 more clk, game_time=4.
//  4) winScreen=1 at game_time=9 -> game_time stays 9 for 100 clk.
//     menuScreen=1 -> game_time=0, IDLE.
//  5) playerDied coincident with tick terminal at game_time=4 -> game_time=0, and no strobe,
//     no tick that clk.
//  6) reset asserted mid-RUN asynchronously -> all outputs 0 before next clk edge.
//     Force game_time to 65534 -> saturates at 65535.

Source files
------------

// File: rtl/game_timer_if.sv
// Handshake bundle between the level FSM and the game timer.
//   menuScreen, winScreen, playerDied, pause_btn : level FSM -> timer controls
//   game_time, tick, stage_strobe, stage_idx, paused : timer -> level sequencer
// master: the level side (drives controls, reads timing)
// slave : the timer side
interface game_timer_if #(
  parameter int TIME_W = 16
);
  logic              menuScreen;
  logic              winScreen;
  logic              playerDied;
  logic              pause_btn;
  logic [TIME_W-1:0] game_time;
  logic              tick;
  logic              stage_strobe;
  logic [4:0]        stage_idx;
  logic              paused;

  modport master (
    output menuScreen, winScreen, playerDied, pause_btn,
    input  game_time, tick, stage_strobe, stage_idx, paused
  );

  modport slave (
    input  menuScreen, winScreen, playerDied, pause_btn,
    output game_time, tick, stage_strobe, stage_idx, paused
  );
endinterface

// File: rtl/game_timer_gen.sv
// game_timer_gen: elapsed game-time counter for the level sequencer.
// Counts prescaled ticks only while a level is active; freezes on menu/win,
// pauses on pause-button rising edges and restarts at 0 behind a respawn hold
// after a death. Also emits stage boundary strobes and a saturating stage index.
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high
//   bus    game_timer_if.slave (controls in, game_time/tick/stage_strobe/
//          stage_idx/paused out; all outputs registered)
module game_timer_gen #(
  parameter int TICK_DIV   = 2_500_000,
  parameter int STAGE_LEN  = 125,
  parameter int DEATH_HOLD = 20,
  parameter int TIME_W     = 16
) (
  input logic         clk,
  input logic         reset,
  game_timer_if.slave bus
);

  localparam int PW = (TICK_DIV   > 1) ? $clog2(TICK_DIV)   : 1;
  localparam int SW = (STAGE_LEN  > 1) ? $clog2(STAGE_LEN)  : 1;
  localparam int HW = (DEATH_HOLD > 1) ? $clog2(DEATH_HOLD) : 1;

  localparam logic [PW-1:0]     PRESC_TC = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0]     SUB_TC   = SW'(STAGE_LEN - 1);
  localparam logic [HW-1:0]     HOLD_TC  = HW'(DEATH_HOLD - 1);
  localparam logic [TIME_W-1:0] TIME_MAX = '1;
  localparam logic [4:0]        IDX_MAX  = 5'd31;

  typedef enum logic [2:0] {IDLE, RUN, PAUSED, HOLD, DONE} state_t;

  state_t            state;
  logic [PW-1:0]     presc;
  logic [SW-1:0]     sub;       // game_time modulo STAGE_LEN
  logic [HW-1:0]     hold_cnt;  // ticks spent in the respawn hold
  logic              pause_q;
  logic [TIME_W-1:0] game_time;
  logic [4:0]        stage_idx;
  logic              tick;
  logic              stage_strobe;
  logic              paused;

  logic pause_edge;
  logic presc_tc;
  logic active;

  assign pause_edge = bus.pause_btn & ~pause_q;
  assign presc_tc   = (presc == PRESC_TC);
  assign active     = (state == RUN) || (state == PAUSED);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      presc        <= '0;
      sub          <= '0;
      hold_cnt     <= '0;
      pause_q      <= 1'b0;
      game_time    <= '0;
      stage_idx    <= '0;
      tick         <= 1'b0;
      stage_strobe <= 1'b0;
      paused       <= 1'b0;
    end else begin
      pause_q      <= bus.pause_btn;
      tick         <= 1'b0;
      stage_strobe <= 1'b0;

      if (bus.menuScreen) begin
        state     <= IDLE;
        presc     <= '0;
        sub       <= '0;
        hold_cnt  <= '0;
        game_time <= '0;
        stage_idx <= '0;
        paused    <= 1'b0;
      end else if (bus.playerDied && (active || state == HOLD)) begin
        // Re-entering HOLD on every cycle the level stays high restarts the hold.
        state     <= HOLD;
        presc     <= '0;
        sub       <= '0;
        hold_cnt  <= '0;
        game_time <= '0;
        stage_idx <= '0;
        paused    <= 1'b0;
      end else if (bus.winScreen && active) begin
        state  <= DONE;
        paused <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (!bus.winScreen) state <= RUN;
          end
          RUN: begin
            // A pause edge beats a terminal count: the prescaler stays put and
            // the tick fires on the first counting cycle after resume.
            if (pause_edge) begin
              state  <= PAUSED;
              paused <= 1'b1;
            end else if (presc_tc) begin
              presc <= '0;
              tick  <= 1'b1;
              if (game_time != TIME_MAX) begin
                game_time <= game_time + 1'b1;
                if (sub == SUB_TC) begin
                  sub          <= '0;
                  stage_strobe <= 1'b1;
                  if (stage_idx != IDX_MAX) stage_idx <= stage_idx + 1'b1;
                end else begin
                  sub <= sub + 1'b1;
                end
              end
            end else begin
              presc <= presc + 1'b1;
            end
          end
          PAUSED: begin
            if (pause_edge) begin
              state  <= RUN;
              paused <= 1'b0;
            end
          end
          HOLD: begin
            // Ticks are counted but never shown; game_time sits at 0.
            if (presc_tc) begin
              presc <= '0;
              if (hold_cnt == HOLD_TC) begin
                hold_cnt <= '0;
                state    <= RUN;
              end else begin
                hold_cnt <= hold_cnt + 1'b1;
              end
            end else begin
              presc <= presc + 1'b1;
            end
          end
          DONE: begin
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.game_time    = game_time;
  assign bus.tick         = tick;
  assign bus.stage_strobe = stage_strobe;
  assign bus.stage_idx    = stage_idx;
  assign bus.paused       = paused;

endmodule

// File: tb/tb_game_timer_gen.sv
// Self-checking bench for game_timer_gen: directed scenarios plus a random run
// against a cycle-level behavioural model; a second small-width instance
// covers game_time and stage_idx saturation.
module tb_game_timer_gen;
  localparam int TD = 4, SL = 5, DH = 3;
  localparam int MI = 0, MR = 1, MP = 2, MH = 3, MD = 4;

  logic clk, reset;
  int total = 0, bad = 0;

  game_timer_if #(.TIME_W(16)) bus ();
  game_timer_if #(.TIME_W(8))  sbus ();

  game_timer_gen #(.TICK_DIV(TD), .STAGE_LEN(SL), .DEATH_HOLD(DH), .TIME_W(16))
    dut (.clk(clk), .reset(reset), .bus(bus));
  game_timer_gen #(.TICK_DIV(2), .STAGE_LEN(5), .DEATH_HOLD(3), .TIME_W(8))
    sdut (.clk(clk), .reset(reset), .bus(sbus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural model
  int m_mode, m_gt, m_phase, m_hold;
  bit m_pq, m_tick, m_strobe;

  task automatic model_reset();
    m_mode = MI; m_gt = 0; m_phase = 0; m_hold = 0;
    m_pq = 0; m_tick = 0; m_strobe = 0;
  endtask

  task automatic model_clk();
    bit edge_s;
    edge_s = bus.pause_btn && !m_pq;
    m_pq = bus.pause_btn;
    m_tick = 0; m_strobe = 0;
    if (bus.menuScreen) begin
      m_mode = MI; m_gt = 0; m_phase = 0; m_hold = 0;
    end else if (bus.playerDied && (m_mode == MR || m_mode == MP || m_mode == MH)) begin
      m_mode = MH; m_gt = 0; m_phase = 0; m_hold = 0;
    end else if (bus.winScreen && (m_mode == MR || m_mode == MP)) begin
      m_mode = MD;
    end else begin
      case (m_mode)
        MI: if (!bus.winScreen) m_mode = MR;
        MR: if (edge_s) m_mode = MP;
            else begin
              m_phase++;
              if (m_phase == TD) begin
                m_phase = 0; m_tick = 1;
                if (m_gt < 65535) begin
                  m_gt++;
                  if (m_gt % SL == 0) m_strobe = 1;
                end
              end
            end
        MP: if (edge_s) m_mode = MR;
        MH: begin
              m_phase++;
              if (m_phase == TD) begin
                m_phase = 0; m_hold++;
                if (m_hold == DH) begin m_mode = MR; m_hold = 0; end
              end
            end
        default: ;
      endcase
    end
  endtask

  function automatic logic [23:0] exp_vec();
    int idx;
    idx = (m_gt / SL > 31) ? 31 : m_gt / SL;
    return {m_gt[15:0], m_tick, m_strobe, idx[4:0], m_mode == MP};
  endfunction

  function automatic logic [23:0] dut_vec();
    return {bus.game_time, bus.tick, bus.stage_strobe, bus.stage_idx, bus.paused};
  endfunction

  task automatic step();
    @(posedge clk);
    model_clk();
    #1;
  endtask

  task automatic set_in(bit menu, bit win, bit died, bit pb);
    bus.menuScreen = menu; bus.winScreen = win; bus.playerDied = died; bus.pause_btn = pb;
  endtask

  task automatic restart();
    set_in(1, 0, 0, 0); step();
    set_in(0, 0, 0, 0); step();
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (dut_vec() !== 24'h0) begin bad++; $display("FAIL reset_hold: got %h want 0", dut_vec()); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    step();
    total++;
    if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL reset_idle: got %h want %h", dut_vec(), exp_vec()); end
  endtask

  task automatic test_count();
    int strobes = 0;
    restart();
    for (int i = 0; i < 200 && m_gt < 10; i++) begin
      step();
      if (bus.stage_strobe === 1'b1) strobes++;
      total++;
      if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL count: got %h want %h", dut_vec(), exp_vec()); end
    end
    total++;
    if (strobes != 2 || bus.stage_idx !== 5'd2 || bus.game_time !== 16'd10) begin
      bad++; $display("FAIL count_stage: strobes=%0d idx=%0d gt=%0d want 2/2/10", strobes, bus.stage_idx, bus.game_time);
    end
  endtask

  task automatic test_death();
    int n;
    restart();
    for (int i = 0; i < 200 && m_gt < 7; i++) step();
    set_in(0, 0, 1, 0); step(); set_in(0, 0, 0, 0);
    total++;
    if (bus.game_time !== 16'd0 || bus.stage_idx !== 5'd0 || dut_vec() !== exp_vec()) begin
      bad++; $display("FAIL death_clear: got %h want %h", dut_vec(), exp_vec());
    end
    n = 0;
    for (int i = 0; i < 40 && bus.tick !== 1'b1; i++) begin
      step(); n++;
      total++;
      if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL death_hold: got %h want %h", dut_vec(), exp_vec()); end
    end
    // 3 hold ticks of 4 clk, then 4 clk to the first visible tick
    total++;
    if (n != 16 || bus.game_time !== 16'd1) begin
      bad++; $display("FAIL death_resume: clk=%0d gt=%0d want 16/1", n, bus.game_time);
    end
  endtask

  task automatic test_pause();
    restart();
    for (int i = 0; i < 200 && !(m_gt == 3 && m_phase == 2); i++) step();
    set_in(0, 0, 0, 1); step();
    total++;
    if (bus.paused !== 1'b1 || dut_vec() !== exp_vec()) begin bad++; $display("FAIL pause_enter: got %h want %h", dut_vec(), exp_vec()); end
    for (int i = 0; i < 50; i++) begin
      step();
      total++;
      if (bus.game_time !== 16'd3 || bus.paused !== 1'b1 || bus.tick !== 1'b0) begin
        bad++; $display("FAIL pause_hold: gt=%0d paused=%b want 3/1", bus.game_time, bus.paused);
      end
    end
    set_in(0, 0, 0, 0); step();
    set_in(0, 0, 0, 1); step();
    step();
    total++;
    if (bus.tick !== 1'b0 || bus.paused !== 1'b0) begin bad++; $display("FAIL pause_resume1: tick=%b paused=%b want 0/0", bus.tick, bus.paused); end
    step();
    total++;
    if (bus.tick !== 1'b1 || bus.game_time !== 16'd4 || dut_vec() !== exp_vec()) begin
      bad++; $display("FAIL pause_resume2: got %h want %h", dut_vec(), exp_vec());
    end
    set_in(0, 0, 0, 0); step();
  endtask

  task automatic test_win();
    restart();
    for (int i = 0; i < 200 && m_gt < 9; i++) step();
    set_in(0, 1, 0, 0);
    for (int i = 0; i < 100; i++) begin
      step();
      total++;
      if (bus.game_time !== 16'd9 || bus.tick !== 1'b0 || bus.paused !== 1'b0) begin
        bad++; $display("FAIL win_freeze: gt=%0d tick=%b want 9/0", bus.game_time, bus.tick);
      end
    end
    set_in(1, 0, 0, 0); step();
    total++;
    if (dut_vec() !== 24'h0) begin bad++; $display("FAIL win_menu: got %h want 0", dut_vec()); end
    set_in(0, 0, 0, 0);
  endtask

  task automatic test_death_on_tick();
    restart();
    for (int i = 0; i < 200 && !(m_gt == 4 && m_phase == TD - 1); i++) step();
    set_in(0, 0, 1, 0); step(); set_in(0, 0, 0, 0);
    total++;
    if (dut_vec() !== 24'h0) begin bad++; $display("FAIL death_on_tick: got %h want 0", dut_vec()); end
  endtask

  task automatic test_random();
    restart();
    for (int i = 0; i < 2000; i++) begin
      set_in($urandom_range(0, 199) == 0, $urandom_range(0, 149) == 0,
             $urandom_range(0, 59) == 0,
             ($urandom_range(0, 24) == 0) ? !bus.pause_btn : bus.pause_btn);
      step();
      total++;
      if (dut_vec() !== exp_vec()) begin bad++; $display("FAIL random[%0d]: got %h want %h", i, dut_vec(), exp_vec()); end
    end
    set_in(0, 0, 0, 0); step();
  endtask

  task automatic test_async_reset();
    restart();
    repeat (10) step();
    reset = 1'b1;
    #2;
    total++;
    if (dut_vec() !== 24'h0 || sbus.game_time !== 8'd0) begin
      bad++; $display("FAIL async_reset: got %h want 0", dut_vec());
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_saturate();
    int n;
    int egt;
    bit etick, estb;
    logic [4:0] eidx;
    sbus.menuScreen = 1'b0;
    n = 0;
    for (int i = 0; i < 530; i++) begin
      @(posedge clk); #1;
      n++;
      // edge 1 enters RUN; ticks on odd edges from 3 onward
      egt   = ((n - 1) / 2 > 255) ? 255 : (n - 1) / 2;
      etick = (n >= 3) && (n % 2 == 1);
      estb  = etick && ((n - 1) / 2 <= 255) && (egt % 5 == 0);
      eidx  = (egt / 5 > 31) ? 5'd31 : 5'(egt / 5);
      total++;
      if (sbus.game_time !== egt[7:0] || sbus.tick !== etick || sbus.stage_strobe !== estb || sbus.stage_idx !== eidx) begin
        bad++; $display("FAIL saturate[%0d]: gt=%0d tick=%b stb=%b idx=%0d want %0d/%b/%b/%0d",
                        n, sbus.game_time, sbus.tick, sbus.stage_strobe, sbus.stage_idx, egt, etick, estb, eidx);
      end
    end
    sbus.menuScreen = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    set_in(1, 0, 0, 0);
    sbus.menuScreen = 1'b1; sbus.winScreen = 1'b0; sbus.playerDied = 1'b0; sbus.pause_btn = 1'b0;
    model_reset();
    test_reset();
    test_count();
    test_death();
    test_pause();
    test_win();
    test_death_on_tick();
    test_random();
    test_async_reset();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
